// File: rtl/hdmi_pkg.sv
// hdmi_pkg: shared raster tracker state, coordinate width and RGB pixel type
package hdmi_pkg;
  localparam int COORD_W = 10;
  typedef enum logic [1:0] {UNLOCKED, WAIT_DE, ACTIVE, BLANK} trk_state_e;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;
endpackage

// File: rtl/hdmi_sync_delay.sv
// hdmi_sync_delay: one-cycle register stage for de/hs/vs/rgb (in: de, hs, vs, rgb; out: *_q), sync active-low rst_n
module hdmi_sync_delay
  import hdmi_pkg::*;
(
  input  logic hdmi_clk,
  input  logic rst_n,
  input  logic de,
  input  logic hs,
  input  logic vs,
  input  rgb_t rgb,
  output logic de_q,
  output logic hs_q,
  output logic vs_q,
  output rgb_t rgb_q
);
  always_ff @(posedge hdmi_clk)
    {de_q, hs_q, vs_q, rgb_q} <= rst_n ? {de, hs, vs, rgb} : '0;
endmodule

// File: rtl/hdmi_raster_tracker.sv
// hdmi_raster_tracker: sync-locked pixel coordinates for a 1-cycle delayed HDMI stream; HDMI_RASTER_MEASURE_EN enables meas_w/meas_h
// in: hdmi_clk, rst_n, hdmi_de/hs/vs, hdmi_r/g/b; out: de/hs/vs/r/g/b_out, pos_x/pos_y, pos_valid, frame_start, overflow, meas_w/meas_h
module hdmi_raster_tracker
  import hdmi_pkg::*;
#(
  parameter logic VS_POL = 1'b1,
  parameter int   MAX_W  = 1023,
  parameter int   MAX_H  = 1023
) (
  input  logic               hdmi_clk,
  input  logic               rst_n,
  input  logic               hdmi_de,
  input  logic               hdmi_hs,
  input  logic               hdmi_vs,
  input  logic [7:0]         hdmi_r,
  input  logic [7:0]         hdmi_g,
  input  logic [7:0]         hdmi_b,
  output logic               de_out,
  output logic               hs_out,
  output logic               vs_out,
  output logic [7:0]         r_out,
  output logic [7:0]         g_out,
  output logic [7:0]         b_out,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic               pos_valid,
  output logic               frame_start,
  output logic               overflow,
  output logic [COORD_W-1:0] meas_w,
  output logic [COORD_W-1:0] meas_h
);
  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(MAX_W);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(MAX_H);
  rgb_t rgb_in, rgb_q;
  trk_state_e state, state_n;
  logic [COORD_W-1:0] y_cnt, y_n, x_n, py_n;
  logic ovf_n, fs_n, cnt_n, vs_edge, de_rise;
  assign rgb_in = {hdmi_r, hdmi_g, hdmi_b};
  assign {r_out, g_out, b_out} = rgb_q;
  hdmi_sync_delay u_dly (
    .hdmi_clk (hdmi_clk),
    .rst_n    (rst_n),
    .de       (hdmi_de),
    .hs       (hdmi_hs),
    .vs       (hdmi_vs),
    .rgb      (rgb_in),
    .de_q     (de_out),
    .hs_q     (hs_out),
    .vs_q     (vs_out),
    .rgb_q    (rgb_q)
  );
  // the delayed copies double as the previous-cycle sync history
  assign vs_edge = (hdmi_vs == VS_POL) && (vs_out != VS_POL);
  assign de_rise = hdmi_de && !de_out;
  // cnt_n marks a pixel that belongs to the tracked raster; pos_y only follows it,
  // so it holds through blanking while y_cnt already points at the next line
  always_comb begin
    state_n = state;
    x_n     = pos_x;
    y_n     = y_cnt;
    py_n    = pos_y;
    ovf_n   = overflow;
    fs_n    = 1'b0;
    cnt_n   = 1'b0;
    if (vs_edge) begin
      state_n = WAIT_DE;
      y_n     = '0;
      ovf_n   = 1'b0;
    end else begin
      case (state)
        WAIT_DE: if (de_rise) begin
          state_n = ACTIVE;
          x_n     = '0;
          py_n    = y_cnt;
          fs_n    = 1'b1;
          cnt_n   = 1'b1;
        end
        ACTIVE: if (hdmi_de) begin
          x_n   = (pos_x == X_MAX) ? X_MAX : pos_x + 10'd1;
          py_n  = y_cnt;
          cnt_n = 1'b1;
          ovf_n = overflow | (x_n == X_MAX);
        end else begin
          state_n = BLANK;
          y_n     = (y_cnt == Y_MAX) ? Y_MAX : y_cnt + 10'd1;
          ovf_n   = overflow | (y_n == Y_MAX);
        end
        BLANK: if (hdmi_de) begin
          state_n = ACTIVE;
          x_n     = '0;
          py_n    = y_cnt;
          cnt_n   = 1'b1;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge hdmi_clk) begin
    if (!rst_n) begin
      state       <= UNLOCKED;
      pos_x       <= '0;
      pos_y       <= '0;
      y_cnt       <= '0;
      overflow    <= 1'b0;
      frame_start <= 1'b0;
      pos_valid   <= 1'b0;
    end else begin
      state       <= state_n;
      pos_x       <= x_n;
      pos_y       <= py_n;
      y_cnt       <= y_n;
      overflow    <= ovf_n;
      frame_start <= fs_n;
      pos_valid   <= cnt_n & ~ovf_n;
    end
  end
`ifdef HDMI_RASTER_MEASURE_EN
  logic [COORD_W-1:0] w_max, x_len;
  assign x_len = (pos_x == X_MAX) ? X_MAX : pos_x + 10'd1;
  // the first vs edge only locks; there is no complete frame behind it yet
  always_ff @(posedge hdmi_clk) begin
    if (!rst_n) begin
      w_max  <= '0;
      meas_w <= '0;
      meas_h <= '0;
    end else if (vs_edge) begin
      w_max <= '0;
      if (state != UNLOCKED) begin
        meas_w <= w_max;
        meas_h <= y_cnt;
      end
    end else if (state == ACTIVE && !hdmi_de && x_len > w_max) begin
      w_max <= x_len;
    end
  end
`else
  assign meas_w = '0;
  assign meas_h = '0;
`endif
endmodule

// File: tb/tb_hdmi_raster_tracker.sv
// tb_hdmi_raster_tracker: scoreboard bench for hdmi_raster_tracker (VS_POL=1 and VS_POL=0 instances)
module tb_hdmi_raster_tracker;
  typedef struct packed {
    logic       de, hs, vs;
    logic [9:0] x, y;
    logic       v, fs, ovf;
    logic [23:0] rgb;
    logic       u1v, u1fs;
    logic [9:0] u1x;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n, hdmi_de, hdmi_hs, hdmi_vs, vs1;
  logic [7:0] hdmi_r, hdmi_g, hdmi_b;
  logic de_out, hs_out, vs_out, pos_valid, frame_start, overflow;
  logic [7:0] r_out, g_out, b_out;
  logic [9:0] pos_x, pos_y, meas_w, meas_h;
  logic u1_de, u1_hs, u1_vs, u1_valid, u1_fs, u1_ovf;
  logic [7:0] u1_r, u1_g, u1_b;
  logic [9:0] u1_x, u1_y, u1_mw, u1_mh;
  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  logic [9:0] ex_x, ex_y, u1x_hold;
  logic ex_ovf;
  always #5 clk = ~clk;
  hdmi_raster_tracker #(.VS_POL(1'b1)) u0 (
    .hdmi_clk(clk), .rst_n(rst_n), .hdmi_de(hdmi_de), .hdmi_hs(hdmi_hs), .hdmi_vs(hdmi_vs),
    .hdmi_r(hdmi_r), .hdmi_g(hdmi_g), .hdmi_b(hdmi_b),
    .de_out(de_out), .hs_out(hs_out), .vs_out(vs_out),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .pos_x(pos_x), .pos_y(pos_y), .pos_valid(pos_valid), .frame_start(frame_start),
    .overflow(overflow), .meas_w(meas_w), .meas_h(meas_h)
  );
  hdmi_raster_tracker #(.VS_POL(1'b0)) u1 (
    .hdmi_clk(clk), .rst_n(rst_n), .hdmi_de(hdmi_de), .hdmi_hs(hdmi_hs), .hdmi_vs(vs1),
    .hdmi_r(hdmi_r), .hdmi_g(hdmi_g), .hdmi_b(hdmi_b),
    .de_out(u1_de), .hs_out(u1_hs), .vs_out(u1_vs),
    .r_out(u1_r), .g_out(u1_g), .b_out(u1_b),
    .pos_x(u1_x), .pos_y(u1_y), .pos_valid(u1_valid), .frame_start(u1_fs),
    .overflow(u1_ovf), .meas_w(u1_mw), .meas_h(u1_mh)
  );
  task automatic step(input string tag, input logic de, input logic [9:0] x, y,
                      input logic v, fs, ovf, input logic u1v, u1fs, input logic [9:0] u1x);
    exp_t e, got;
    hdmi_de = de;
    hdmi_hs = 1'($urandom);
    {hdmi_r, hdmi_g, hdmi_b} = 24'($urandom);
    e = rst_n ? {de, hdmi_hs, hdmi_vs, x, y, v, fs, ovf, hdmi_r, hdmi_g, hdmi_b, u1v, u1fs, u1x} : '0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    got = {de_out, hs_out, vs_out, pos_x, pos_y, pos_valid, frame_start, overflow,
           r_out, g_out, b_out, u1_valid, u1_fs, u1_x};
    tests++;
    assert (got === e) else begin
      fails++;
      $error("FAIL %s got %h exp %h", tag, got, e);
    end
  endtask
  task automatic pix(input string tag, input int x, y, input logic fs, ovf);
    ex_x = 10'(x);
    ex_y = 10'(y);
    ex_ovf = ovf;
    step(tag, 1'b1, ex_x, ex_y, ~ovf, fs, ovf, 1'b0, 1'b0, u1x_hold);
  endtask
  task automatic blank(input string tag);
    step(tag, 1'b0, ex_x, ex_y, 1'b0, 1'b0, ex_ovf, 1'b0, 1'b0, u1x_hold);
  endtask
  task automatic ign(input string tag);
    step(tag, 1'b1, ex_x, ex_y, 1'b0, 1'b0, ex_ovf, 1'b0, 1'b0, u1x_hold);
  endtask
  task automatic chk(input string tag, input logic [9:0] got, exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  initial begin
    rst_n = 1'b0;
    hdmi_de = 1'b0;
    hdmi_hs = 1'b0;
    hdmi_vs = 1'b0;
    vs1 = 1'b1;
    {hdmi_r, hdmi_g, hdmi_b} = '0;
    ex_x = '0;
    ex_y = '0;
    ex_ovf = 1'b0;
    u1x_hold = '0;
    for (int i = 0; i < 5; i++) ign("reset");
    chk("reset_meas_w", meas_w, 10'd0);
    chk("reset_meas_h", meas_h, 10'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step("unlocked", 1'(i >> 1), 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
    hdmi_vs = 1'b1;
    blank("vs_lock");
    hdmi_vs = 1'b0;
    blank("vs_low");
    blank("vs_low");
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < 64; i++) pix("line64", i, l, l == 0 && i == 0, 1'b0);
      for (int i = 0; i < 4; i++) blank("hblank");
    end
    for (int i = 0; i < 20; i++) pix("pre_midvs", i, 3, 1'b0, 1'b0);
    hdmi_vs = 1'b1;
    ign("midvs_edge");
    hdmi_vs = 1'b0;
    for (int i = 0; i < 3; i++) ign("midvs_ignored");
    blank("midvs_fall");
    blank("midvs_blank");
    for (int i = 0; i < 10; i++) pix("after_midvs", i, 0, i == 0, 1'b0);
    blank("after_midvs_blank");
    hdmi_vs = 1'b1;
    blank("ovf_vs");
    hdmi_vs = 1'b0;
    blank("ovf_vs_low");
    for (int i = 0; i < 1030; i++) pix("long_line", i >= 1023 ? 1023 : i, 0, i == 0, i >= 1023);
    blank("ovf_sticky");
    blank("ovf_sticky");
    hdmi_vs = 1'b1;
    ex_ovf = 1'b0;
    blank("ovf_clear");
    hdmi_vs = 1'b0;
    blank("meas_vs_low");
    for (int l = 0; l < 48; l++) begin
      for (int i = 0; i < 80; i++) pix("meas_frame", i, l, l == 0 && i == 0, 1'b0);
      for (int i = 0; i < 4; i++) blank("meas_hblank");
    end
    hdmi_vs = 1'b1;
    blank("meas_vs");
`ifdef HDMI_RASTER_MEASURE_EN
    chk("meas_w", meas_w, 10'd80);
    chk("meas_h", meas_h, 10'd48);
`else
    chk("meas_w_off", meas_w, 10'd0);
    chk("meas_h_off", meas_h, 10'd0);
`endif
    hdmi_vs = 1'b0;
    vs1 = 1'b0;
    rst_n = 1'b0;
    ign("midframe_reset");
    ign("midframe_reset");
    rst_n = 1'b1;
    ex_x = '0;
    ex_y = '0;
    ex_ovf = 1'b0;
    blank("post_reset");
    vs1 = 1'b1;
    blank("pol0_rise");
    blank("pol0_rise");
    for (int i = 0; i < 4; i++) ign("pol0_unlocked");
    blank("pol0_blank");
    vs1 = 1'b0;
    blank("pol0_fall");
    blank("pol0_fall");
    for (int i = 0; i < 4; i++)
      step("pol0_line", 1'b1, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, i == 0, 10'(i));
    u1x_hold = 10'd3;
    blank("pol0_hold");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
